// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   IFU_XLEN / IFU_BUS_W : PC/address width and instruction-bus data width
//   IFU_FAULT_*          : 2-bit fault codes carried to decode with each instruction
//   RESP_OKAY            : the only bus read response that is not an access fault
//   ifu_state_e          : fetch FSM state encoding
package ifu_fetch_pkg;

   localparam int IFU_XLEN  = 64;
   localparam int IFU_BUS_W = 64;

   localparam logic [1:0] IFU_FAULT_NONE     = 2'b00;
   localparam logic [1:0] IFU_FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] IFU_FAULT_ACCESS   = 2'b10;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      IFU_ST_IDLE = 2'd0,
      IFU_ST_AR   = 2'd1,
      IFU_ST_R    = 2'd2,
      IFU_ST_OUT  = 2'd3
   } ifu_state_e;

endpackage

// File: rtl/ifu_align.sv
// Combinational beat-to-instruction alignment.
//   pc_sel : pc[2] of the fetch, picks the upper or lower 32-bit word of the beat
//   beat   : 64-bit read beat from the instruction bus
//   resp   : bus read response
//   inst   : selected instruction, forced to zero on an access fault
//   fault  : IFU_FAULT_ACCESS on any non-OKAY response, else IFU_FAULT_NONE
module ifu_align
   import ifu_fetch_pkg::*;
#(
   parameter int BUS_W = IFU_BUS_W
) (
   input  logic             pc_sel,
   input  logic [BUS_W-1:0] beat,
   input  logic [1:0]       resp,
   output logic [31:0]      inst,
   output logic [1:0]       fault
);

   always_comb begin
      inst  = 32'h0;
      fault = IFU_FAULT_NONE;
      if (resp != RESP_OKAY) begin
         fault = IFU_FAULT_ACCESS;
      end else begin
         inst = pc_sel ? beat[63:32] : beat[31:0];
      end
   end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: takes a PC, issues one single-beat read on the
// AR/R channel pair, and hands the selected 32-bit word plus its PC and fault
// code to decode under a valid/ready handshake. Only one fetch is ever
// outstanding; flush_i kills in-flight or buffered work.
//   clk, rst                         : clock, async active-low reset
//   pc_i, pc_valid_i, pc_ready_o     : PC stage handshake
//   flush_i                          : redirect/trap kill
//   ar_valid_o, ar_ready_i, ar_addr_o: read-address channel
//   r_valid_i, r_ready_o, r_data_i, r_resp_i : read-data channel
//   inst_o, inst_pc_o, inst_fault_o, inst_valid_o, inst_ready_i : decode handshake
//
// state | meaning
// IDLE  | waiting for a PC; pc_ready_o high unless flush_i
// AR    | read address presented, waiting for ar_ready_i
// R     | waiting for the read beat (always consumed, even when killed)
// OUT   | instruction held for decode until inst_ready_i or flush_i
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter int XLEN  = IFU_XLEN,
   parameter int BUS_W = IFU_BUS_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  pc_i,
   input  logic             pc_valid_i,
   output logic             pc_ready_o,
   input  logic             flush_i,
   output logic             ar_valid_o,
   input  logic             ar_ready_i,
   output logic [XLEN-1:0]  ar_addr_o,
   input  logic             r_valid_i,
   output logic             r_ready_o,
   input  logic [BUS_W-1:0] r_data_i,
   input  logic [1:0]       r_resp_i,
   output logic [31:0]      inst_o,
   output logic [XLEN-1:0]  inst_pc_o,
   output logic             inst_valid_o,
   input  logic             inst_ready_i,
   output logic [1:0]       inst_fault_o
);

   ifu_state_e       state;
   logic             kill;
   logic             pc_rdy_q;
   logic [31:0]      al_inst;
   logic [1:0]       al_fault;

   // pc_rdy_q is high only while IDLE; it comes up one edge after reset
   // release so pc_ready_o is low for the whole time rst is asserted.
   assign pc_ready_o = pc_rdy_q & ~flush_i;

   ifu_align #(.BUS_W(BUS_W)) u_align (
      .pc_sel (inst_pc_o[2]),
      .beat   (r_data_i),
      .resp   (r_resp_i),
      .inst   (al_inst),
      .fault  (al_fault)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IFU_ST_IDLE;
         kill         <= 1'b0;
         pc_rdy_q     <= 1'b0;
         ar_valid_o   <= 1'b0;
         ar_addr_o    <= '0;
         r_ready_o    <= 1'b0;
         inst_valid_o <= 1'b0;
         inst_o       <= 32'h0;
         inst_pc_o    <= '0;
         inst_fault_o <= IFU_FAULT_NONE;
      end else begin
         case (state)
            IFU_ST_IDLE: begin
               pc_rdy_q <= 1'b1;
               if (pc_valid_i && pc_ready_o) begin
                  pc_rdy_q  <= 1'b0;
                  inst_pc_o <= pc_i;
                  if (pc_i[1:0] != 2'b00) begin
                     // Misaligned PC never touches the bus.
                     state        <= IFU_ST_OUT;
                     inst_o       <= 32'h0;
                     inst_fault_o <= IFU_FAULT_MISALIGN;
                     inst_valid_o <= 1'b1;
                  end else begin
                     state      <= IFU_ST_AR;
                     ar_valid_o <= 1'b1;
                     ar_addr_o  <= {pc_i[XLEN-1:3], 3'b000};
                  end
               end
            end

            IFU_ST_AR: begin
               // A flush only marks the fetch dead; the address stays up
               // until the bus takes it.
               if (flush_i) kill <= 1'b1;
               if (ar_ready_i) begin
                  state      <= IFU_ST_R;
                  ar_valid_o <= 1'b0;
                  r_ready_o  <= 1'b1;
               end
            end

            IFU_ST_R: begin
               if (r_valid_i) begin
                  r_ready_o <= 1'b0;
                  if (kill || flush_i) begin
                     state    <= IFU_ST_IDLE;
                     kill     <= 1'b0;
                     pc_rdy_q <= 1'b1;
                  end else begin
                     state        <= IFU_ST_OUT;
                     inst_o       <= al_inst;
                     inst_fault_o <= al_fault;
                     inst_valid_o <= 1'b1;
                  end
               end else if (flush_i) begin
                  kill <= 1'b1;
               end
            end

            IFU_ST_OUT: begin
               if (flush_i || inst_ready_i) begin
                  state        <= IFU_ST_IDLE;
                  inst_valid_o <= 1'b0;
                  pc_rdy_q     <= 1'b1;
               end
            end

            default: begin
               state <= IFU_ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

   localparam int XLEN  = 64;
   localparam int BUS_W = 64;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [XLEN-1:0]  pc_i = '0;
   logic             pc_valid_i = 1'b0;
   logic             pc_ready_o;
   logic             flush_i = 1'b0;
   logic             ar_valid_o;
   logic             ar_ready_i = 1'b0;
   logic [XLEN-1:0]  ar_addr_o;
   logic             r_valid_i = 1'b0;
   logic             r_ready_o;
   logic [BUS_W-1:0] r_data_i = '0;
   logic [1:0]       r_resp_i = 2'b00;
   logic [31:0]      inst_o;
   logic [XLEN-1:0]  inst_pc_o;
   logic             inst_valid_o;
   logic             inst_ready_i = 1'b0;
   logic [1:0]       inst_fault_o;

   int n_vec = 0;
   int n_err = 0;

   ifu_fetch #(.XLEN(XLEN), .BUS_W(BUS_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_i         (pc_i),
      .pc_valid_i   (pc_valid_i),
      .pc_ready_o   (pc_ready_o),
      .flush_i      (flush_i),
      .ar_valid_o   (ar_valid_o),
      .ar_ready_i   (ar_ready_i),
      .ar_addr_o    (ar_addr_o),
      .r_valid_i    (r_valid_i),
      .r_ready_o    (r_ready_o),
      .r_data_i     (r_data_i),
      .r_resp_i     (r_resp_i),
      .inst_o       (inst_o),
      .inst_pc_o    (inst_pc_o),
      .inst_valid_o (inst_valid_o),
      .inst_ready_i (inst_ready_i),
      .inst_fault_o (inst_fault_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Reference: {fault, inst} for a fetch of pc returning (data, resp).
   function automatic logic [33:0] model(input logic [63:0] pc, input logic [63:0] data,
                                         input logic [1:0] resp);
      logic [63:0] sh;
      if (pc % 4 != 0) return {2'b01, 32'h0};
      if (resp != 2'b00) return {2'b10, 32'h0};
      sh = data >> (((pc / 4) % 2) * 32);
      return {2'b00, sh[31:0]};
   endfunction

   // One complete fetch with optional bus / decode stalls; if flush_out, the
   // instruction is killed in OUT with flush_i and inst_ready_i together.
   task automatic do_fetch(input logic [63:0] pc, input logic [63:0] data, input logic [1:0] resp,
                           input int ar_wait, input int r_wait, input int out_wait,
                           input bit flush_out);
      logic [33:0]  exp;
      logic [100:0] got, want;
      logic [64:0]  ag, aw;
      int t;
      exp = model(pc, data, resp);
      tick();
      pc_i = pc;
      pc_valid_i = 1'b1;
      mid();
      t = 0;
      while (pc_ready_o !== 1'b1 && t < 20) begin
         tick();
         mid();
         t++;
      end
      n_vec++;
      if (pc_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL pc_ready_wait: got %b want 1", pc_ready_o);
      end
      tick();
      pc_valid_i = 1'b0;
      pc_i = {$urandom, $urandom};
      mid();
      if (pc[1:0] == 2'b00) begin
         aw = {1'b1, pc & ~64'h7};
         for (int i = 0; i <= ar_wait; i++) begin
            if (i > 0) begin
               tick();
               mid();
            end
            ag = {ar_valid_o, ar_addr_o};
            n_vec++;
            if (ag !== aw || inst_valid_o !== 1'b0 || pc_ready_o !== 1'b0) begin
               n_err++;
               $display("FAIL ar_phase pc=%h: got ar=%h iv=%b pr=%b want ar=%h iv=0 pr=0",
                        pc, ag, inst_valid_o, pc_ready_o, aw);
            end
         end
         ar_ready_i = 1'b1;
         tick();
         ar_ready_i = 1'b0;
         mid();
         for (int i = 0; i <= r_wait; i++) begin
            if (i > 0) begin
               r_data_i = {$urandom, $urandom};
               tick();
               mid();
            end
            n_vec++;
            if ({r_ready_o, ar_valid_o, pc_ready_o, inst_valid_o} !== 4'b1000) begin
               n_err++;
               $display("FAIL r_phase pc=%h: got rr/av/pr/iv=%b want 1000",
                        pc, {r_ready_o, ar_valid_o, pc_ready_o, inst_valid_o});
            end
         end
         r_valid_i = 1'b1;
         r_data_i  = data;
         r_resp_i  = resp;
         tick();
         r_valid_i = 1'b0;
         r_data_i  = {$urandom, $urandom};
         r_resp_i  = 2'b00;
         mid();
      end else begin
         n_vec++;
         if (ar_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_no_bus pc=%h: got ar_valid=%b want 0", pc, ar_valid_o);
         end
      end
      want = {1'b1, exp, pc, 1'b0, 1'b0};
      for (int i = 0; i <= out_wait; i++) begin
         if (i > 0) begin
            tick();
            mid();
         end
         got = {inst_valid_o, inst_fault_o, inst_o, inst_pc_o, pc_ready_o, r_ready_o};
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL out_phase pc=%h: got %h want %h", pc, got, want);
         end
      end
      inst_ready_i = 1'b1;
      flush_i = flush_out;
      tick();
      inst_ready_i = 1'b0;
      flush_i = 1'b0;
      mid();
      n_vec++;
      if ({inst_valid_o, pc_ready_o} !== 2'b01) begin
         n_err++;
         $display("FAIL out_release pc=%h: got iv/pr=%b want 01", pc, {inst_valid_o, pc_ready_o});
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      pc_valid_i = 1'b1;
      pc_i = 64'h8000_0000;
      #12;
      n_vec++;
      if ({pc_ready_o, ar_valid_o, ar_addr_o, r_ready_o, inst_o, inst_pc_o, inst_valid_o,
           inst_fault_o} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got pr=%b av=%b aa=%h rr=%b i=%h ipc=%h iv=%b f=%b want all 0",
                  pc_ready_o, ar_valid_o, ar_addr_o, r_ready_o, inst_o, inst_pc_o,
                  inst_valid_o, inst_fault_o);
      end
      mid();
      pc_valid_i = 1'b0;
      rst = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_directed();
      do_fetch(64'h8000_0000, 64'h0000_0013_0010_0093, 2'b00, 0, 0, 0, 1'b0);
      do_fetch(64'h8000_0004, 64'h0000_0013_0010_0093, 2'b00, 0, 0, 0, 1'b0);
      do_fetch(64'h8000_0002, 64'h0000_0013_0010_0093, 2'b00, 0, 0, 0, 1'b0);
      do_fetch(64'h8000_0008, 64'hdead_beef_cafe_f00d, 2'b10, 0, 0, 0, 1'b0);
   endtask

   task automatic test_flush_idle();
      tick();
      flush_i = 1'b1;
      pc_valid_i = 1'b1;
      pc_i = 64'h8000_0100;
      #1;
      n_vec++;
      if (pc_ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL flush_idle_ready: got %b want 0", pc_ready_o);
      end
      tick();
      flush_i = 1'b0;
      pc_valid_i = 1'b0;
      mid();
      n_vec++;
      if ({ar_valid_o, inst_valid_o, pc_ready_o} !== 3'b001) begin
         n_err++;
         $display("FAIL flush_idle_ignored: got av/iv/pr=%b want 001",
                  {ar_valid_o, inst_valid_o, pc_ready_o});
      end
   endtask

   task automatic test_flush_ar();
      logic [64:0] aw;
      aw = {1'b1, 64'h8000_1008};
      tick();
      pc_i = 64'h8000_100c;
      pc_valid_i = 1'b1;
      tick();
      pc_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         flush_i = (i == 1);
         ar_ready_i = (i == 3);
         mid();
         n_vec++;
         if ({ar_valid_o, ar_addr_o} !== aw || inst_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ar_hold cyc=%0d: got ar=%h iv=%b want ar=%h iv=0",
                     i, {ar_valid_o, ar_addr_o}, inst_valid_o, aw);
         end
         tick();
      end
      flush_i = 1'b0;
      ar_ready_i = 1'b0;
      mid();
      n_vec++;
      if ({r_ready_o, ar_valid_o, pc_ready_o, inst_valid_o} !== 4'b1000) begin
         n_err++;
         $display("FAIL flush_ar_r: got rr/av/pr/iv=%b want 1000",
                  {r_ready_o, ar_valid_o, pc_ready_o, inst_valid_o});
      end
      r_valid_i = 1'b1;
      r_data_i = 64'h1111_2222_3333_4444;
      tick();
      r_valid_i = 1'b0;
      mid();
      n_vec++;
      if ({inst_valid_o, pc_ready_o, r_ready_o} !== 3'b010) begin
         n_err++;
         $display("FAIL flush_ar_drop: got iv/pr/rr=%b want 010",
                  {inst_valid_o, pc_ready_o, r_ready_o});
      end
      tick();
      mid();
      n_vec++;
      if (inst_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL flush_ar_later: got iv=%b want 0", inst_valid_o);
      end
   endtask

   task automatic test_back_to_back_flush();
      tick();
      pc_i = 64'h8000_2000;
      pc_valid_i = 1'b1;
      tick();
      pc_valid_i = 1'b0;
      ar_ready_i = 1'b1;
      tick();
      ar_ready_i = 1'b0;
      pc_i = 64'h8000_3004;
      pc_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         flush_i = (i < 2);
         mid();
         n_vec++;
         if ({r_ready_o, ar_valid_o, pc_ready_o, inst_valid_o} !== 4'b1000) begin
            n_err++;
            $display("FAIL b2b_flush cyc=%0d: got rr/av/pr/iv=%b want 1000",
                     i, {r_ready_o, ar_valid_o, pc_ready_o, inst_valid_o});
         end
         tick();
      end
      flush_i = 1'b0;
      r_valid_i = 1'b1;
      r_data_i = 64'h5555_6666_7777_8888;
      tick();
      r_valid_i = 1'b0;
      mid();
      n_vec++;
      if ({inst_valid_o, ar_valid_o, pc_ready_o} !== 3'b001) begin
         n_err++;
         $display("FAIL b2b_after_beat: got iv/av/pr=%b want 001",
                  {inst_valid_o, ar_valid_o, pc_ready_o});
      end
      pc_valid_i = 1'b0;
      do_fetch(64'h8000_3004, 64'h0badf00d_12345678, 2'b00, 0, 0, 0, 1'b0);
   endtask

   task automatic test_out_stall_flush();
      do_fetch(64'h8000_4004, 64'haaaa_bbbb_cccc_dddd, 2'b00, 1, 1, 4, 1'b1);
   endtask

   task automatic test_reset_mid();
      tick();
      pc_i = 64'h8000_5000;
      pc_valid_i = 1'b1;
      tick();
      pc_valid_i = 1'b0;
      ar_ready_i = 1'b1;
      tick();
      ar_ready_i = 1'b0;
      pc_valid_i = 1'b1;
      mid();
      n_vec++;
      if (r_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL reset_mid_pre: got rr=%b want 1", r_ready_o);
      end
      #1;
      rst = 1'b0;
      #1;
      n_vec++;
      if ({pc_ready_o, ar_valid_o, ar_addr_o, r_ready_o, inst_o, inst_pc_o, inst_valid_o,
           inst_fault_o} !== '0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: got pr=%b av=%b aa=%h rr=%b iv=%b ipc=%h want all 0",
                  pc_ready_o, ar_valid_o, ar_addr_o, r_ready_o, inst_valid_o, inst_pc_o);
      end
      pc_valid_i = 1'b0;
      mid();
      rst = 1'b1;
      tick();
      do_fetch(64'h8000_5004, 64'h0000_0073_0000_0013, 2'b00, 0, 0, 0, 1'b0);
   endtask

   task automatic test_random();
      logic [63:0] pc, data;
      logic [1:0]  resp;
      for (int k = 0; k < 40; k++) begin
         pc = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
         else if (pc[1:0] == 2'b00) pc[1:0] = 2'(($urandom_range(1, 3)));
         data = {$urandom, $urandom};
         resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         do_fetch(pc, data, resp, $urandom_range(0, 2), $urandom_range(0, 2),
                  $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_flush_idle();
      test_flush_ar();
      test_back_to_back_flush();
      test_out_stall_flush();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current fetch PC and issues a single-beat read on the instruction bus (AR/R channel pair).
- Extracts the 32-bit instruction from the returned 64-bit beat and holds it with its PC for decode under a valid/ready handshake.
- Back-pressures the PC stage via pc_ready_o and drops wrong-path fetches on flush_i.

Parameters:
- XLEN, 64, PC/address width.
- BUS_W, 64, instruction-bus data width; must be 64 (pc[2] selects the word).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_i  in  XLEN  fetch PC from the PC stage.
- pc_valid_i  in  1  pc_i valid.
- pc_ready_o  out  1  fetch accepts pc_i this cycle; PC stage holds (PCOP_NONE) when low.
- flush_i  in  1  redirect/trap; kills in-flight and buffered fetch.
- ar_valid_o  out  1  read address valid.
- ar_ready_i  in  1  read address accepted.
- ar_addr_o  out  XLEN  8-byte-aligned address, pc & ~7.
- r_valid_i  in  1  read data valid.
- r_ready_o  out  1  fetch accepts read data.
- r_data_i  in  BUS_W  read beat.
- r_resp_i  in  2  00 OKAY; any nonzero value is an access fault.
- inst_o  out  32  instruction to decode.
- inst_pc_o  out  XLEN  PC of inst_o.
- inst_valid_o  out  1  inst_o/inst_pc_o/inst_fault_o valid.
- inst_ready_i  in  1  decode accepts.
- inst_fault_o  out  2  00 none, 01 misaligned, 10 access fault.

Behaviour:
- Reset (rst=0, async): state IDLE, kill=0; all outputs 0 (inst_o, inst_pc_o, inst_fault_o, ar_addr_o, valids, pc_ready_o, r_ready_o). Reset asserted mid-transaction abandons it; the bus is reset by the same rst.
- States:
  - IDLE: pc_ready_o=1 unless flush_i. Accept on pc_valid_i & pc_ready_o and latch pc.
    - pc[1:0]!=0: go to OUT with fault=01, inst=0, no bus access.
    - Otherwise go to AR.
  - AR: ar_valid_o=1 with ar_addr_o stable. On ar_ready_i go to R. ar_valid_o never drops before handshake, even under flush.
  - R: r_ready_o=1. On r_valid_i:
    - kill=1: go to IDLE with no output and clear kill.
    - Otherwise go to OUT. inst = pc[2] ? data[63:32] : data[31:0]. fault = 10 if r_resp_i!=0 (inst forced to 0), else 00.
  - OUT: inst_valid_o=1 and outputs stable. On inst_ready_i go to IDLE.
- pc_ready_o is low in AR/R/OUT: one fetch outstanding, no overlap.
- Minimum latency, zero-wait bus:
  - pc accepted in cycle N.
  - ar_valid_o in N+1, with ar_ready_i=1.
  - r_valid_i in N+2.
  - inst_valid_o in N+3.
  - Next pc accepted in N+4 at the earliest.
  - Throughput: one instruction per 4 cycles.
- Flush, by state (flush_i has priority over every same-cycle event):
  - IDLE: pc_valid_i ignored that cycle.
  - AR or R: set kill and complete the bus transaction. The response is still consumed (r_ready_o=1) and discarded.
  - OUT: go to IDLE and drop inst_valid_o next cycle, even if inst_ready_i=1 the same cycle.
  - OUT with kill set is unreachable.
- A flush arriving while kill is already set has no further effect.
- Back-to-back flushes never create a second outstanding request.
- Fetch for a new PC after a killed transaction starts only after its R beat returns. pc_ready_o is low throughout.
- inst_pc_o always equals the accepted pc (full XLEN, not aligned).

Decomposition:
- Shared package/sysconfig holds:
  - XLEN, reused from existing config.
  - IFU_FAULT_NONE/MISALIGN/ACCESS (2-bit).
  - IFU_ST_IDLE/AR/R/OUT state encoding.
  - RESP_OKAY.
- One sub-module, ifu_align: combinational word-select by pc[2], resp-to-fault mapping and inst zeroing on fault. The FSM and registers stay in ifu_fetch.

Test Plan:
- Reset release, pc_i=0x80000000 valid, zero-wait bus, r_data_i=0x00000013_00100093, inst_ready_i=1 -> ar_addr_o=0x80000000 in N+1; inst_o=0x00100093, fault=00, inst_valid_o in N+3; pc_ready_o=1 in N+4.
- pc_i=0x80000004, same beat -> inst_o=0x00000013, inst_pc_o=0x80000004.
- pc_i=0x80000002 -> no ar_valid_o; inst_valid_o in N+1 with fault=01, inst_o=0, inst_pc_o=0x80000002.
- r_resp_i=2'b10 -> inst_valid_o with fault=10, inst_o=0.
- ar_ready_i held low 3 cycles, flush_i pulsed in 2nd cycle -> ar_valid_o/ar_addr_o stable until handshake; R beat consumed; inst_valid_o never asserts; pc_ready_o returns 1 the cycle after the R beat.
- In OUT, inst_ready_i=0 for 4 cycles -> outputs stable, pc_ready_o=0; then flush_i together with inst_ready_i=1 -> inst_valid_o=0 next cycle, IDLE. Async rst asserted mid-R -> all outputs 0 immediately.
